// File: rtl/ctrl_seq.sv
// Five-state (T0..T4) microcode sequencer for a small accumulator CPU.
// Turns the T-state and opcode into bus-drive, load and PC control strobes.
module ctrl_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       flag_c,
   input  logic       flag_z,
   output logic       pc_out,
   output logic       ram_out,
   output logic       ir_out,
   output logic       a_out,
   output logic       alu_out,
   output logic       mar_in,
   output logic       ir_in,
   output logic       a_in,
   output logic       b_in,
   output logic       ram_in,
   output logic       out_in,
   output logic       pc_en,
   output logic       pc_jmp,
   output logic       alu_sub,
   output logic [2:0] tstate,
   output logic       halted
);

   typedef enum logic [2:0] {
      StT0 = 3'd0,
      StT1 = 3'd1,
      StT2 = 3'd2,
      StT3 = 3'd3,
      StT4 = 3'd4
   } tstate_e;

   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpLdi = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpJz  = 4'h8;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   tstate_e r_state;
   tstate_e w_state_nxt;
   logic    r_halted;
   logic    w_halted_nxt;
   logic    w_active;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StT0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   // HLT freezes the counter at T2 on the edge that would have left it.
   always_comb begin
      w_state_nxt  = r_state;
      w_halted_nxt = r_halted;
      if (!r_halted && run) begin
         if (r_state == StT2 && opcode == OpHlt) begin
            w_halted_nxt = 1'b1;
         end else begin
            unique case (r_state)
               StT0:    w_state_nxt = StT1;
               StT1:    w_state_nxt = StT2;
               StT2:    w_state_nxt = StT3;
               StT3:    w_state_nxt = StT4;
               StT4:    w_state_nxt = StT0;
               default: w_state_nxt = StT0;
            endcase
         end
      end
   end

   assign w_active = run & ~r_halted;

   // Control decode
   always_comb begin
      pc_out  = 1'b0;
      ram_out = 1'b0;
      ir_out  = 1'b0;
      a_out   = 1'b0;
      alu_out = 1'b0;
      mar_in  = 1'b0;
      ir_in   = 1'b0;
      a_in    = 1'b0;
      b_in    = 1'b0;
      ram_in  = 1'b0;
      out_in  = 1'b0;
      pc_en   = 1'b0;
      pc_jmp  = 1'b0;
      alu_sub = 1'b0;
      if (w_active) begin
         unique case (r_state)
            StT0: begin
               pc_out = 1'b1;
               mar_in = 1'b1;
            end
            StT1: begin
               ram_out = 1'b1;
               ir_in   = 1'b1;
               pc_en   = 1'b1;
            end
            StT2: begin
               case (opcode)
                  OpLda, OpAdd, OpSub, OpSta: begin
                     ir_out = 1'b1;
                     mar_in = 1'b1;
                  end
                  OpLdi: begin
                     ir_out = 1'b1;
                     a_in   = 1'b1;
                  end
                  OpJmp: begin
                     ir_out = 1'b1;
                     pc_jmp = 1'b1;
                  end
                  OpJc: begin
                     ir_out = flag_c;
                     pc_jmp = flag_c;
                  end
                  OpJz: begin
                     ir_out = flag_z;
                     pc_jmp = flag_z;
                  end
                  OpOut: begin
                     a_out  = 1'b1;
                     out_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            StT3: begin
               case (opcode)
                  OpLda: begin
                     ram_out = 1'b1;
                     a_in    = 1'b1;
                  end
                  OpAdd, OpSub: begin
                     ram_out = 1'b1;
                     b_in    = 1'b1;
                     alu_sub = (opcode == OpSub);
                  end
                  OpSta: begin
                     a_out  = 1'b1;
                     ram_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            StT4: begin
               if (opcode == OpAdd || opcode == OpSub) begin
                  alu_out = 1'b1;
                  a_in    = 1'b1;
                  alu_sub = (opcode == OpSub);
               end
            end
            default: ;
         endcase
      end
   end

   assign tstate = r_state;
   assign halted = r_halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed and randomized checks for ctrl_seq against a table-driven reference.
module tb_ctrl_seq;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [3:0] opcode;
   logic       flag_c;
   logic       flag_z;
   logic       pc_out, ram_out, ir_out, a_out, alu_out;
   logic       mar_in, ir_in, a_in, b_in, ram_in, out_in;
   logic       pc_en, pc_jmp, alu_sub;
   logic [2:0] tstate;
   logic       halted;

   logic [15:0] w_ctrl;
   int          n_checks;
   int          n_errors;

   // Control word bit positions
   localparam logic [15:0] PcOut  = 16'h2000;
   localparam logic [15:0] RamOut = 16'h1000;
   localparam logic [15:0] IrOut  = 16'h0800;
   localparam logic [15:0] AOut   = 16'h0400;
   localparam logic [15:0] AluOut = 16'h0200;
   localparam logic [15:0] MarIn  = 16'h0100;
   localparam logic [15:0] IrIn   = 16'h0080;
   localparam logic [15:0] AIn    = 16'h0040;
   localparam logic [15:0] BIn    = 16'h0020;
   localparam logic [15:0] RamIn  = 16'h0010;
   localparam logic [15:0] OutIn  = 16'h0008;
   localparam logic [15:0] PcEn   = 16'h0004;
   localparam logic [15:0] PcJmp  = 16'h0002;
   localparam logic [15:0] AluSub = 16'h0001;

   ctrl_seq u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .opcode  (opcode),
      .flag_c  (flag_c),
      .flag_z  (flag_z),
      .pc_out  (pc_out),
      .ram_out (ram_out),
      .ir_out  (ir_out),
      .a_out   (a_out),
      .alu_out (alu_out),
      .mar_in  (mar_in),
      .ir_in   (ir_in),
      .a_in    (a_in),
      .b_in    (b_in),
      .ram_in  (ram_in),
      .out_in  (out_in),
      .pc_en   (pc_en),
      .pc_jmp  (pc_jmp),
      .alu_sub (alu_sub),
      .tstate  (tstate),
      .halted  (halted)
   );

   assign w_ctrl = {2'b00, pc_out, ram_out, ir_out, a_out, alu_out, mar_in, ir_in, a_in,
                    b_in, ram_in, out_in, pc_en, pc_jmp, alu_sub};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [2:0] ts, input logic [15:0] ctl);
      check_eq({tag, "_ts"}, {13'd0, tstate}, {13'd0, ts});
      check_eq({tag, "_ctl"}, w_ctrl, ctl);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reset with given run/opcode, check the in-reset outputs, release between edges.
   task automatic do_reset(input logic r, input logic [3:0] op);
      @(negedge clk);
      run    = r;
      opcode = op;
      rst_n  = 1'b0;
      #1;
      check_state("in_reset", 3'd0, r ? (PcOut | MarIn) : 16'h0000);
      check_eq("in_reset_halted", {15'd0, halted}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Reference decode from the instruction table.
   function automatic logic [15:0] model_ctrl(input logic [2:0] ts, input logic [3:0] op,
                                              input logic c, input logic z, input logic r,
                                              input logic hl);
      logic [15:0] v;
      v = 16'h0000;
      if (r && !hl) begin
         case (ts)
            3'd0: v = PcOut | MarIn;
            3'd1: v = RamOut | IrIn | PcEn;
            3'd2: begin
               case (op)
                  4'h1, 4'h2, 4'h3, 4'h4: v = IrOut | MarIn;
                  4'h5: v = IrOut | AIn;
                  4'h6: v = IrOut | PcJmp;
                  4'h7: v = c ? (IrOut | PcJmp) : 16'h0000;
                  4'h8: v = z ? (IrOut | PcJmp) : 16'h0000;
                  4'hE: v = AOut | OutIn;
                  default: v = 16'h0000;
               endcase
            end
            3'd3: begin
               case (op)
                  4'h1: v = RamOut | AIn;
                  4'h2: v = RamOut | BIn;
                  4'h3: v = RamOut | BIn | AluSub;
                  4'h4: v = AOut | RamIn;
                  default: v = 16'h0000;
               endcase
            end
            3'd4: begin
               if (op == 4'h2) v = AluOut | AIn;
               else if (op == 4'h3) v = AluOut | AIn | AluSub;
            end
            default: v = 16'h0000;
         endcase
      end
      return v;
   endfunction

   initial begin
      logic [2:0] m_ts;
      logic       m_hl;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      run      = 1'b0;
      opcode   = 4'h0;
      flag_c   = 1'b0;
      flag_z   = 1'b0;

      // Reset with run=0: all controls quiet
      do_reset(1'b0, 4'h2);
      check_state("idle_after_rst", 3'd0, 16'h0000);

      // ADD full cycle
      do_reset(1'b1, 4'h2);
      check_state("add_t0", 3'd0, PcOut | MarIn);
      tick(); check_state("add_t1", 3'd1, RamOut | IrIn | PcEn);
      tick(); check_state("add_t2", 3'd2, IrOut | MarIn);
      tick(); check_state("add_t3", 3'd3, RamOut | BIn);
      tick(); check_state("add_t4", 3'd4, AluOut | AIn);
      tick(); check_state("add_wrap", 3'd0, PcOut | MarIn);

      // JC not taken, then taken
      opcode = 4'h7;
      flag_c = 1'b0;
      tick(); tick(); #1;
      check_state("jc_nc_t2", 3'd2, 16'h0000);
      tick(); check_state("jc_t3", 3'd3, 16'h0000);
      tick(); check_state("jc_t4", 3'd4, 16'h0000);
      tick(); tick(); tick();
      flag_c = 1'b1;
      #1;
      check_state("jc_c_t2", 3'd2, IrOut | PcJmp);
      // JZ follows the zero flag combinationally in T2
      opcode = 4'h8;
      flag_z = 1'b0;
      #1;
      check_state("jz_nz_t2", 3'd2, 16'h0000);
      flag_z = 1'b1;
      #1;
      check_state("jz_z_t2", 3'd2, IrOut | PcJmp);

      // STA and OUT / LDI decode in T2/T3
      do_reset(1'b1, 4'h4);
      tick(); tick(); tick();
      check_state("sta_t3", 3'd3, AOut | RamIn);
      do_reset(1'b1, 4'hE);
      tick(); tick();
      check_state("out_t2", 3'd2, AOut | OutIn);
      opcode = 4'h5;
      #1;
      check_state("ldi_t2", 3'd2, IrOut | AIn);

      // HLT: freezes at T2, ignores run and opcode
      do_reset(1'b1, 4'hF);
      tick(); tick();
      check_state("hlt_t2", 3'd2, 16'h0000);
      check_eq("hlt_t2_halted", {15'd0, halted}, 16'd0);
      tick();
      opcode = 4'h1;
      for (int i = 0; i < 10; i++) begin
         run = i[0];
         #1;
         check_state("halt_hold", 3'd2, 16'h0000);
         check_eq("halt_flag", {15'd0, halted}, 16'd1);
         tick();
      end
      // Reset out of halt
      do_reset(1'b1, 4'h1);
      check_state("unhalt", 3'd0, PcOut | MarIn);

      // SUB with run dropped in T3
      do_reset(1'b1, 4'h3);
      tick(); tick(); tick();
      run = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_state("sub_pause", 3'd3, 16'h0000);
         tick();
      end
      run = 1'b1;
      #1;
      check_state("sub_resume_t3", 3'd3, RamOut | BIn | AluSub);
      tick(); check_state("sub_t4", 3'd4, AluOut | AIn | AluSub);

      // Asynchronous reset mid-LDA
      do_reset(1'b1, 4'h1);
      tick(); tick(); tick();
      check_state("lda_t3", 3'd3, RamOut | AIn);
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 3'd0, PcOut | MarIn);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the reference model
      do_reset(1'b1, 4'h0);
      m_ts = 3'd0;
      m_hl = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         run    = ($urandom_range(0, 7) != 0);
         opcode = 4'($urandom_range(0, 14));
         flag_c = 1'($urandom_range(0, 1));
         flag_z = 1'($urandom_range(0, 1));
         #1;
         check_state("rnd", m_ts, model_ctrl(m_ts, opcode, flag_c, flag_z, run, m_hl));
         check_eq("rnd_bus_onehot", {15'd0, ($countones(w_ctrl[13:9]) <= 1)}, 16'd1);
         check_eq("rnd_pc_excl", {15'd0, pc_en & pc_jmp}, 16'd0);
         @(posedge clk);
         if (!m_hl && run) begin
            if (m_ts == 3'd2 && opcode == 4'hF) m_hl = 1'b1;
            else m_ts = (m_ts == 3'd4) ? 3'd0 : m_ts + 3'd1;
         end
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
